// File: rtl/fp_rounder.sv
// Round-half-up stage of the 8-bit float converter: renormalises on significand carry, saturates at max.
// One cycle from in_valid to out_valid; accepts a new input every cycle and never stalls.
module fp_rounder #(
  parameter int EXP_W  = 3,
  parameter int MANT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [EXP_W-1:0]  E_in,
  input  logic [MANT_W-1:0] F_in,
  input  logic              Sixth,
  output logic              out_valid,
  output logic [EXP_W-1:0]  E_out,
  output logic [MANT_W-1:0] F_out,
  output logic              ovf
);

  logic [MANT_W:0]     mant_sum;
  logic [EXP_W:0]      exp_sum;
  logic [EXP_W-1:0]    e_nxt;
  logic [MANT_W-1:0]   f_nxt;
  logic                ovf_nxt;

  // One extra bit on each adder exposes the carry-out.
  assign mant_sum = {1'b0, F_in} + {{MANT_W{1'b0}}, 1'b1};
  assign exp_sum  = {1'b0, E_in} + {{EXP_W{1'b0}}, 1'b1};

  always_comb begin
    e_nxt   = E_in;
    f_nxt   = F_in;
    ovf_nxt = 1'b0;
    if (Sixth) begin
      if (!mant_sum[MANT_W]) begin
        f_nxt = mant_sum[MANT_W-1:0];
      end else if (!exp_sum[EXP_W]) begin
        // Significand wrapped to 1 followed by zeros: shift right, bump exponent.
        f_nxt = mant_sum[MANT_W:1];
        e_nxt = exp_sum[EXP_W-1:0];
      end else begin
        f_nxt   = {MANT_W{1'b1}};
        e_nxt   = {EXP_W{1'b1}};
        ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      E_out     <= '0;
      F_out     <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        E_out <= e_nxt;
        F_out <= f_nxt;
        ovf   <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fp_rounder.sv
// Scoreboard bench for fp_rounder: a reference model queues expected results as inputs are driven.
module tb_fp_rounder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] E_in = '0;
  logic [4:0] F_in = '0;
  logic       Sixth = 1'b0;
  logic       out_valid;
  logic [2:0] E_out;
  logic [4:0] F_out;
  logic       ovf;

  int total = 0;
  int bad = 0;

  logic [8:0] exp_q[$];  // {E, F, ovf}
  logic [8:0] last_res;
  logic       started = 1'b0;

  fp_rounder #(.EXP_W(3), .MANT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .E_in(E_in), .F_in(F_in), .Sixth(Sixth),
    .out_valid(out_valid), .E_out(E_out), .F_out(F_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [8:0] model(input int e, input int f, input bit s);
    if (!s)          return {e[2:0], f[4:0], 1'b0};
    else if (f < 31) return {e[2:0], 5'(f + 1), 1'b0};
    else if (e < 7)  return {3'(e + 1), 5'd16, 1'b0};
    else             return {3'd7, 5'd31, 1'b1};
  endfunction

  task automatic drive(input bit r, input bit v, input int e, input int f, input bit s);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    E_in     = e[2:0];
    F_in     = f[4:0];
    Sixth    = s;
    if (v && !r) exp_q.push_back(model(e, f, s));
  endtask

  // Monitor: capture controls at the edge, check outputs 1 ns later.
  always @(posedge clk) begin
    logic r_s, v_s;
    logic [8:0] want;
    r_s = rst;
    v_s = in_valid;
    #1;
    if (r_s) begin
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", {23'd0, E_out, F_out, ovf}, 32'd0);
      last_res = '0;
      started  = 1'b1;
    end else if (started) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, v_s});
      if (v_s) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          want = exp_q.pop_front();
          chk("result", {23'd0, E_out, F_out, ovf}, {23'd0, want});
          last_res = want;
        end
      end else begin
        chk("hold", {23'd0, E_out, F_out, ovf}, {23'd0, last_res});
      end
    end
  end

  initial begin
    // Reset with a valid input already presented
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    // Directed vectors
    drive(0, 1, 1, 31, 1);
    drive(0, 1, 3, 22, 1);
    drive(0, 1, 3, 22, 0);
    drive(0, 1, 7, 31, 1);
    drive(0, 1, 7, 30, 1);
    drive(0, 1, 2, 15, 1);   // unnormalized: carry into MSB, exponent unchanged
    drive(0, 1, 6, 31, 1);
    drive(0, 0, 5, 5, 1);
    drive(0, 0, 1, 1, 0);
    drive(0, 1, 4, 9, 0);
    // Back-to-back random traffic with idle gaps
    for (int i = 0; i < 40; i++)
      drive(0, ($urandom_range(3) != 0), $urandom_range(7), $urandom_range(31), $urandom_range(1));
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // Reset the cycle after a valid input
    drive(0, 1, 7, 31, 1);
    drive(1, 1, 3, 3, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 31, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
